// File: rtl/cordic_fsm_v2_pkg.sv
// +----------------------------------------------------------------------------+
// | cordic_fsm_v2_pkg : shared state and variable encodings for the CORDIC FSM |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package cordic_fsm_v2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RST_REG  = 4'd1,
    ST_LOAD_IN  = 4'd2,
    ST_ITER     = 4'd3,
    ST_SHIFT    = 4'd4,
    ST_ADD_BEG  = 4'd5,
    ST_ADD_WAIT = 4'd6,
    ST_STORE    = 4'd7,
    ST_NEXT_IT  = 4'd8,
    ST_OUT      = 4'd9,
    ST_DONE     = 4'd10
  } state_t;

  localparam logic [1:0] VAR_X = 2'b00;
  localparam logic [1:0] VAR_Y = 2'b01;
  localparam logic [1:0] VAR_Z = 2'b10;

endpackage

`default_nettype wire

// File: rtl/cordic_fsm_v2.sv
// +----------------------------------------------------------------------------+
// | cordic_fsm_v2 : sequencer for the iterative single-adder sin/cos CORDIC    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module cordic_fsm_v2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       beg_FSM_CORDIC,
  input  logic       ACK_FSM_CORDIC,
  input  logic       operation,
  input  logic [1:0] shift_region_flag,
  input  logic [1:0] cont_var,
  input  logic       ready_add_subt,
  input  logic       max_tick_iter,
  input  logic       min_tick_iter,
  input  logic       max_tick_var,
  input  logic       min_tick_var,
  output logic       reset_reg_cordic,
  output logic       ready_CORDIC,
  output logic       beg_add_subt,
  output logic       ack_add_subt,
  output logic       sel_mux_1,
  output logic [1:0] sel_mux_2,
  output logic       sel_mux_3,
  output logic       mode,
  output logic       enab_cont_iter,
  output logic       load_cont_iter,
  output logic       enab_cont_var,
  output logic       load_cont_var,
  output logic       enab_RB1,
  output logic       enab_RB2,
  output logic       enab_d_ff_Xn,
  output logic       enab_d_ff_Yn,
  output logic       enab_d_ff_Zn,
  output logic       enab_d_ff_out,
  output logic       enab_dff_shifted_x,
  output logic       enab_dff_shifted_y,
  output logic       enab_dff_LUT,
  output logic       enab_dff_sign
);

  import cordic_fsm_v2_pkg::*;

  state_t state_q;
  state_t state_d;

  // The first-count flag of the variable counter carries no sequencing information.
  logic unused_min_tick_var;
  assign unused_min_tick_var = min_tick_var;

  always_comb begin
    state_d            = state_q;
    reset_reg_cordic   = 1'b0;
    ready_CORDIC       = 1'b0;
    beg_add_subt       = 1'b0;
    ack_add_subt       = 1'b0;
    sel_mux_1          = 1'b0;
    sel_mux_2          = 2'b00;
    sel_mux_3          = operation ^ shift_region_flag[1] ^ shift_region_flag[0];
    mode               = 1'b0;
    enab_cont_iter     = 1'b0;
    load_cont_iter     = 1'b0;
    enab_cont_var      = 1'b0;
    load_cont_var      = 1'b0;
    enab_RB1           = 1'b0;
    enab_RB2           = 1'b0;
    enab_d_ff_Xn       = 1'b0;
    enab_d_ff_Yn       = 1'b0;
    enab_d_ff_Zn       = 1'b0;
    enab_d_ff_out      = 1'b0;
    enab_dff_shifted_x = 1'b0;
    enab_dff_shifted_y = 1'b0;
    enab_dff_LUT       = 1'b0;
    enab_dff_sign      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beg_FSM_CORDIC) state_d = ST_RST_REG;
      end
      ST_RST_REG: begin
        reset_reg_cordic = 1'b1;
        load_cont_iter   = 1'b1;
        load_cont_var    = 1'b1;
        state_d          = ST_LOAD_IN;
      end
      ST_LOAD_IN: begin
        enab_RB1 = 1'b1;
        state_d  = ST_ITER;
      end
      ST_ITER: begin
        // First iteration takes the raw inputs; later ones the fed-back Xn/Yn/Zn.
        sel_mux_1 = ~min_tick_iter;
        enab_RB2  = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        enab_dff_shifted_x = 1'b1;
        enab_dff_shifted_y = 1'b1;
        enab_dff_LUT       = 1'b1;
        enab_dff_sign      = 1'b1;
        state_d            = ST_ADD_BEG;
      end
      ST_ADD_BEG: begin
        beg_add_subt = 1'b1;
        sel_mux_2    = cont_var;
        state_d      = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        sel_mux_2 = cont_var;
        if (ready_add_subt) state_d = ST_STORE;
      end
      ST_STORE: begin
        ack_add_subt  = 1'b1;
        enab_cont_var = 1'b1;
        sel_mux_2     = cont_var;
        case (cont_var)
          VAR_X:   enab_d_ff_Xn = 1'b1;
          VAR_Y:   enab_d_ff_Yn = 1'b1;
          VAR_Z:   enab_d_ff_Zn = 1'b1;
          default: ;
        endcase
        state_d = max_tick_var ? ST_NEXT_IT : ST_ADD_BEG;
      end
      ST_NEXT_IT: begin
        if (max_tick_iter) begin
          state_d = ST_OUT;
        end else begin
          enab_cont_iter = 1'b1;
          state_d        = ST_ITER;
        end
      end
      ST_OUT: begin
        enab_d_ff_out = 1'b1;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        ready_CORDIC = 1'b1;
        if (ACK_FSM_CORDIC) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_fsm_v2.sv
// Directed/randomized bench for cordic_fsm_v2: a scripted conversion model
// predicts every output of every cycle.
`default_nettype none

module tb_cordic_fsm_v2;

  logic       clk = 1'b0;
  logic       reset, beg_FSM_CORDIC, ACK_FSM_CORDIC, operation;
  logic [1:0] shift_region_flag, cont_var;
  logic       ready_add_subt, max_tick_iter, min_tick_iter, max_tick_var, min_tick_var;
  logic       reset_reg_cordic, ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1;
  logic [1:0] sel_mux_2;
  logic       sel_mux_3, mode, enab_cont_iter, load_cont_iter, enab_cont_var, load_cont_var;
  logic       enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_d_ff_out;
  logic       enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_fsm_v2 dut (
    .clk(clk), .reset(reset), .beg_FSM_CORDIC(beg_FSM_CORDIC), .ACK_FSM_CORDIC(ACK_FSM_CORDIC),
    .operation(operation), .shift_region_flag(shift_region_flag), .cont_var(cont_var),
    .ready_add_subt(ready_add_subt), .max_tick_iter(max_tick_iter), .min_tick_iter(min_tick_iter),
    .max_tick_var(max_tick_var), .min_tick_var(min_tick_var),
    .reset_reg_cordic(reset_reg_cordic), .ready_CORDIC(ready_CORDIC),
    .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt), .sel_mux_1(sel_mux_1),
    .sel_mux_2(sel_mux_2), .sel_mux_3(sel_mux_3), .mode(mode),
    .enab_cont_iter(enab_cont_iter), .load_cont_iter(load_cont_iter),
    .enab_cont_var(enab_cont_var), .load_cont_var(load_cont_var),
    .enab_RB1(enab_RB1), .enab_RB2(enab_RB2), .enab_d_ff_Xn(enab_d_ff_Xn),
    .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn), .enab_d_ff_out(enab_d_ff_out),
    .enab_dff_shifted_x(enab_dff_shifted_x), .enab_dff_shifted_y(enab_dff_shifted_y),
    .enab_dff_LUT(enab_dff_LUT), .enab_dff_sign(enab_dff_sign)
  );

  // Bit positions of the packed output vector (sel_mux_3 is checked on its own).
  localparam int B_RST = 0,  B_RDY = 1,  B_BEG = 2,  B_ACK = 3,  B_SM1 = 4,  B_SM2 = 5;
  localparam int B_ECI = 8,  B_LDI = 9,  B_ECV = 10, B_LDV = 11, B_RB1 = 12, B_RB2 = 13;
  localparam int B_XN  = 14, B_YN  = 15, B_ZN  = 16, B_OUT = 17, B_SHX = 18, B_SHY = 19;
  localparam int B_LUT = 20, B_SGN = 21;

  logic [21:0] act;
  assign act = {enab_dff_sign, enab_dff_LUT, enab_dff_shifted_y, enab_dff_shifted_x,
                enab_d_ff_out, enab_d_ff_Zn, enab_d_ff_Yn, enab_d_ff_Xn, enab_RB2, enab_RB1,
                load_cont_var, enab_cont_var, load_cont_iter, enab_cont_iter, mode,
                sel_mux_2, sel_mux_1, ack_add_subt, beg_add_subt, ready_CORDIC, reset_reg_cordic};

  function automatic logic [21:0] bv(input int i);
    return 22'(1) << i;
  endfunction

  function automatic logic [21:0] sm2(input int v);
    return 22'(v) << B_SM2;
  endfunction

  // Output select is the parity of operation and both quadrant flag bits.
  function automatic logic exp_s3();
    return ((int'(operation) + int'(shift_region_flag[1]) + int'(shift_region_flag[0])) % 2) == 1;
  endfunction

  task automatic cyc(input string tag, input logic [21:0] exp);
    logic s3;
    #1;
    s3 = exp_s3();
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: outputs observed %h expected %h", tag, act, exp);
    end
    checks++;
    assert (sel_mux_3 === s3) else begin
      errors++;
      $error("FAIL %s_sel_mux_3: observed %b expected %b", tag, sel_mux_3, s3);
    end
    @(posedge clk);
    #1;
  endtask

  // Randomize every input whose value the current state must ignore.
  task automatic junk();
    beg_FSM_CORDIC = 1'($urandom);
    ACK_FSM_CORDIC = 1'($urandom);
    ready_add_subt = 1'($urandom);
    max_tick_iter  = 1'($urandom);
    min_tick_iter  = 1'($urandom);
    max_tick_var   = 1'($urandom);
    min_tick_var   = 1'($urandom);
    cont_var       = 2'($urandom);
  endtask

  task automatic run_conv(input int n_iter);
    int vs[$];
    int lat;
    logic [21:0] en;
    operation         = 1'($urandom);
    shift_region_flag = 2'($urandom);
    junk(); beg_FSM_CORDIC = 1'b1;
    cyc("idle_beg", '0);
    junk(); cyc("rst_reg", bv(B_RST) | bv(B_LDI) | bv(B_LDV));
    junk(); cyc("load_in", bv(B_RB1));
    for (int it = 0; it < n_iter; it++) begin
      junk(); min_tick_iter = (it == 0);
      cyc("iter", bv(B_RB2) | ((it == 0) ? 22'(0) : bv(B_SM1)));
      junk(); cyc("shift", bv(B_SHX) | bv(B_SHY) | bv(B_LUT) | bv(B_SGN));
      vs = '{0, 1, 2};
      if ($urandom_range(0, 2) == 0) vs = '{0, 1, 3, 2};
      for (int k = 0; k < vs.size(); k++) begin
        junk(); cont_var = 2'(vs[k]);
        cyc("add_beg", bv(B_BEG) | sm2(vs[k]));
        lat = $urandom_range(0, 3);
        for (int w = 0; w < lat; w++) begin
          junk(); cont_var = 2'(vs[k]); ready_add_subt = 1'b0;
          cyc("add_wait", sm2(vs[k]));
        end
        junk(); cont_var = 2'(vs[k]); ready_add_subt = 1'b1;
        cyc("add_wait_rdy", sm2(vs[k]));
        junk(); cont_var = 2'(vs[k]); max_tick_var = (k == vs.size() - 1);
        en = (vs[k] == 0) ? bv(B_XN) : (vs[k] == 1) ? bv(B_YN) : (vs[k] == 2) ? bv(B_ZN) : 22'(0);
        cyc("store", bv(B_ACK) | bv(B_ECV) | sm2(vs[k]) | en);
      end
      junk(); max_tick_iter = (it == n_iter - 1);
      cyc("next_it", (it == n_iter - 1) ? 22'(0) : bv(B_ECI));
    end
    junk(); cyc("out", bv(B_OUT));
    lat = $urandom_range(0, 3);
    for (int w = 0; w < lat; w++) begin
      junk(); ACK_FSM_CORDIC = 1'b0;
      cyc("done_hold", bv(B_RDY));
    end
    junk(); ACK_FSM_CORDIC = 1'b1; beg_FSM_CORDIC = 1'b1;
    cyc("done_ack", bv(B_RDY));
    junk(); beg_FSM_CORDIC = 1'b0;
    cyc("idle_after", '0);
  endtask

  initial begin
    reset = 1'b1; beg_FSM_CORDIC = 1'b0; ACK_FSM_CORDIC = 1'b0; operation = 1'b0;
    shift_region_flag = 2'b00; cont_var = 2'b00; ready_add_subt = 1'b0;
    max_tick_iter = 1'b0; min_tick_iter = 1'b0; max_tick_var = 1'b0; min_tick_var = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("reset_idle", '0);

    // Output select over every operation/quadrant combination while idle.
    for (int c = 0; c < 8; c++) begin
      operation = 1'(c >> 2);
      shift_region_flag = 2'(c);
      beg_FSM_CORDIC = 1'b0;
      cyc("idle_sel3", '0);
    end

    run_conv(1);
    run_conv(2);
    for (int n = 0; n < 6; n++) run_conv($urandom_range(1, 4));

    // Reset while waiting on the adder must abandon the conversion.
    junk(); beg_FSM_CORDIC = 1'b1; cyc("r_idle_beg", '0);
    junk(); cyc("r_rst_reg", bv(B_RST) | bv(B_LDI) | bv(B_LDV));
    junk(); cyc("r_load_in", bv(B_RB1));
    junk(); min_tick_iter = 1'b1; cyc("r_iter", bv(B_RB2));
    junk(); cyc("r_shift", bv(B_SHX) | bv(B_SHY) | bv(B_LUT) | bv(B_SGN));
    junk(); cont_var = 2'b01; cyc("r_add_beg", bv(B_BEG) | sm2(1));
    junk(); cont_var = 2'b01; ready_add_subt = 1'b1; reset = 1'b1;
    cyc("r_add_wait", sm2(1));
    reset = 1'b0; junk(); beg_FSM_CORDIC = 1'b0;
    cyc("r_after_reset", '0);
    junk(); beg_FSM_CORDIC = 1'b0;
    cyc("r_idle_stays", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
